// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq -- iterative RV32M multiply/divide sequencer
//
// Sits beside the single-cycle ALU in the execute stage. It takes one
// M-extension operation per in_valid/in_ready handshake. It runs either a
// shift-add multiplier or a restoring divider for XLEN cycles, and both
// algorithms share a single adder. The result is returned through an
// out_valid/out_ready handshake. While busy is high the pipeline stalls.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operation request
//   in_ready   request can be accepted (high only in IDLE)
//   op         funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   src1       rs1 value (multiplicand / dividend)
//   src2       rs2 value (multiplier / divisor)
//   flush      abort the current operation and discard its result
//   out_valid  result available
//   out_ready  consumer accepts the result
//   result     operation result, held until the next DONE
//   busy       high in CALC or DONE, drives the execute-stage stall
// -----------------------------------------------------------------------------
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [2:0]          op_q;
    logic [CW-1:0]       cnt_q;
    logic [XLEN-1:0]     opa_q;      // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0]   acc_q;      // {hi, multiplier} or {remainder, quotient}
    logic                neg_res_q;  // negate product / quotient
    logic                neg_rem_q;  // negate remainder (dividend was negative)
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;
    logic [XLEN-1:0]     result_q;

    // ------------------------------------------------------------------
    // Accept-time decode, taken straight from the request inputs
    // ------------------------------------------------------------------
    logic            src1_signed, src2_signed;
    logic            neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;
    logic            is_div_in;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] opa_d;
    logic [2*XLEN-1:0] acc_init_d;

    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so that no path leaves it unassigned and no latch is inferred.
    always_comb begin
        src1_signed = 1'b0;
        src2_signed = 1'b0;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                src1_signed = 1'b1;
                src2_signed = 1'b1;
            end
            OP_MULHSU: src1_signed = 1'b1;
            default: ;
        endcase

        neg1 = src1_signed & src1[XLEN-1];
        neg2 = src2_signed & src2[XLEN-1];
        mag1 = neg1 ? -src1 : src1;
        mag2 = neg2 ? -src2 : src2;

        is_div_in = op[2];
        div_zero  = is_div_in && (src2 == '0);
        // Signed overflow applies to DIV and REM only; op[0] marks the unsigned forms.
        div_ovf   = is_div_in && !op[0] && (src1 == MIN_NEG) && (src2 == '1);
        special   = div_zero || div_ovf;

        // op[1] separates REM/REMU from DIV/DIVU inside the divide group.
        if (div_zero) begin
            special_res = op[1] ? src1 : '1;
        end else begin
            special_res = op[1] ? '0 : MIN_NEG;
        end

        // The multiplier starts in the low half and is shifted out as the
        // product moves in. The dividend starts in the low half and is
        // shifted into the remainder one bit per step.
        opa_d      = is_div_in ? mag2 : mag1;
        acc_init_d = is_div_in ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
    end

    // ------------------------------------------------------------------
    // One iteration step through a single shared adder
    // ------------------------------------------------------------------
    logic [XLEN:0]     add_a, add_b;
    logic              add_sub;
    logic [XLEN+1:0]   sum;
    logic [2*XLEN-1:0] acc_d;
    logic [2*XLEN-1:0] prod_d;
    logic [XLEN-1:0]   quot_d, rem_d;
    logic [XLEN-1:0]   final_res_d;

    always_comb begin
        // For divide, the partial remainder after the left shift can need
        // XLEN+1 bits. The top accumulator bit therefore joins the trial
        // subtraction.
        if (op_q[2]) begin
            add_a   = acc_q[2*XLEN-1:XLEN-1];
            add_b   = {1'b0, opa_q};
            add_sub = 1'b1;
        end else begin
            add_a   = {1'b0, acc_q[2*XLEN-1:XLEN]};
            add_b   = {1'b0, opa_q};
            add_sub = 1'b0;
        end

        // One extra bit of width lets sum[XLEN+1] act as the borrow/sign of the
        // trial subtraction.
        sum = {1'b0, add_a}
            + ({1'b0, add_b} ^ {(XLEN+2){add_sub}})
            + {{(XLEN+1){1'b0}}, add_sub};

        acc_d = acc_q;
        if (op_q[2]) begin
            if (sum[XLEN+1]) begin
                // Trial went negative: restore, i.e. plain shift with quotient bit 0.
                acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            end else begin
                acc_d = {sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else begin
            if (acc_q[0]) begin
                acc_d = {sum[XLEN:0], acc_q[XLEN-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[2*XLEN-1:1]};
            end
        end

        // Sign correction and result select. These are only captured on the
        // last step.
        prod_d = neg_res_q ? -acc_d : acc_d;
        quot_d = neg_res_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        rem_d  = neg_rem_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];

        case (op_q)
            OP_MUL:                        final_res_d = prod_d[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_res_d = prod_d[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_res_d = quot_d;
            OP_REM, OP_REMU:               final_res_d = rem_d;
            default:                       final_res_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered handshake outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments.
    // All registers then update together at the edge, whatever the order of
    // the statements.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            opa_q       <= '0;
            acc_q       <= '0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
        end else if (flush) begin
            // The abort drops any request offered in the same cycle. The last
            // delivered result stays on the output.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        op_q       <= op;
                        opa_q      <= opa_d;
                        acc_q      <= acc_init_d;
                        neg_res_q  <= neg1 ^ neg2;
                        neg_rem_q  <= neg1;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (special) begin
                            result_q    <= special_res;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q     <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    acc_q <= acc_d;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        cnt_q       <= '0;
                        result_q    <= final_res_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// -----------------------------------------------------------------------------
// tb_mdu_seq -- directed and random checks of the RV32M sequencer
//
// Expected results come from constants and from a behavioural reference
// model that uses native signed/unsigned arithmetic. They are queued when a
// request is accepted and compared when the DUT presents out_valid.
// -----------------------------------------------------------------------------
module tb_mdu_seq;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mdu_seq #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference model built on the language's own arithmetic operators.
    function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub_s, p;
        logic [63:0] up;
        int ia, ib;
        sa   = $signed({{32{a[31]}}, a});
        sb   = $signed({{32{b[31]}}, b});
        ub_s = $signed({32'h0, b});
        ia   = a;
        ib   = b;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub_s; return p[63:32]; end
            3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Issue one request and wait for its result. hold > 0 keeps out_ready
    // low for that many cycles after out_valid rises.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input int hold);
        int lat;
        int exp_lat;
        bit seen_ready;
        bit seen_idle;
        bit stable;
        logic [31:0] got;
        logic [31:0] want;
        exp_lat = (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
                  ? 1 : XLEN + 1;
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1);
        in_valid  = 1'b1;
        op        = o;
        src1      = a;
        src2      = b;
        out_ready = (hold == 0);
        @(posedge clk);
        exp_q.push_back(expv);
        lat        = 0;
        seen_ready = 1'b0;
        seen_idle  = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                // Scramble the operands so that any late sampling is noticed.
                in_valid = 1'b0;
                src1     = $urandom;
                src2     = $urandom;
                op       = 3'($urandom);
            end
            if (in_ready) seen_ready = 1'b1;
            if (!busy)    seen_idle  = 1'b1;
        end while (!out_valid && lat < 200);
        check("latency", lat, exp_lat);
        check("in_ready_low_while_busy", {31'h0, seen_ready}, 0);
        check("busy_high_while_busy", {31'h0, seen_idle}, 0);
        want = exp_q.pop_front();
        if (!out_valid) begin
            flush = 1'b1;
            @(negedge clk);
            flush     = 1'b0;
            out_ready = 1'b1;
            return;
        end
        got = result;
        check("result", got, want);
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (!out_valid || result !== got) stable = 1'b0;
            end
            check("backpressure_stable", {31'h0, stable}, 1);
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("out_valid_after_hs", out_valid, 0);
        check("in_ready_after_hs", in_ready, 1);
        check("busy_after_hs", busy, 0);
        check("result_held", result, want);
    endtask

    initial begin
        bit seen;
        logic [2:0] ro;
        logic [31:0] ra, rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 3'd0;
        src1      = '0;
        src2      = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_result", result, 0);
        rst = 1'b0;

        // Directed cases with known answers
        run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
        run_op(3'd5, 32'd100,       32'd7,         32'd14,        0);
        run_op(3'd7, 32'd100,       32'd7,         32'd2,         0);

        // Divide by zero and signed overflow complete one cycle after accept
        run_op(3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'd5,         32'd0,         32'd5,         0);
        run_op(3'd5, 32'd9,         32'd0,         32'hFFFF_FFFF, 0);
        run_op(3'd7, 32'd9,         32'd0,         32'd9,         0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0);

        // Backpressure in DONE, then back-to-back requests
        run_op(3'd0, 32'd1234,      32'd5678,      32'd7006652,   10);
        run_op(3'd4, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 0);
        run_op(3'd6, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 0);

        // Flush in the middle of CALC
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; src1 = 32'd3; src2 = 32'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", in_ready, 1);
        check("flush_busy", busy, 0);
        check("flush_out_valid", out_valid, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_result", {31'h0, seen}, 0);

        // A flush in the same cycle as an accept drops the request
        in_valid = 1'b1; flush = 1'b1; op = 3'd1; src1 = 32'd11; src2 = 32'd13;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_accept_in_ready", in_ready, 1);
        check("flush_accept_busy", busy, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_accept_no_result", {31'h0, seen}, 0);

        // Reset in the middle of CALC, then a normal request
        in_valid = 1'b1; op = 3'd0; src1 = 32'd21; src2 = 32'd2;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_result", result, 0);
        run_op(3'd3, 32'd3, 32'd5, 32'd0, 0);

        // Random operations against the reference model
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) rb = 32'($urandom_range(1, 20));
            if (i % 8 == 3) rb = 32'hFFFF_FFFF;
            if (i % 6 == 0) rb = 32'h0;
            run_op(ro, ra, rb, ref_mdu(ro, ra, rb), (i % 5 == 2) ? 3 : 0);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
